// File: rtl/prbs_pkg.sv
// Shared constants, symbol codes and FSM encoding for the PRBS9 transmit generator.
package prbs_pkg;

  localparam int PRBS_LEN    = 9;
  localparam int PRBS_TAP    = 4;
  localparam int PRBS_PERIOD = 511;

  localparam logic [PRBS_LEN-1:0] SEED_I = 9'h1AA;
  localparam logic [PRBS_LEN-1:0] SEED_Q = 9'h1FE;

  localparam logic [1:0] SYM_P1 = 2'b01;
  localparam logic [1:0] SYM_M1 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } txState_t;

  // Bit 0 maps to +1, bit 1 maps to -1 (two's complement, 2 bits)
  function automatic logic [1:0] symbolOf(input logic b);
    return b ? SYM_M1 : SYM_P1;
  endfunction

endpackage

// File: rtl/prbs9_lfsr.sv
// 9-bit Fibonacci LFSR for x^9 + x^5 + 1; an all-zero seed load is replaced by SEED.
module prbs9_lfsr
  import prbs_pkg::*;
#(
  parameter logic [PRBS_LEN-1:0] SEED = SEED_I
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                load,
  input  logic                advance,
  input  logic [PRBS_LEN-1:0] seedIn,
  output logic                outBit
);

  logic [PRBS_LEN-1:0] lfsr;

  // Zero would lock the register up, so it can never be loaded
  always_ff @(posedge clock) begin
    if (i_reset) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= (seedIn == '0) ? SEED : seedIn;
    end else if (advance) begin
      lfsr <= {lfsr[PRBS_LEN-2:0], lfsr[PRBS_LEN-1] ^ lfsr[PRBS_TAP]};
    end
  end

  assign outBit = lfsr[PRBS_LEN-1];

endmodule

// File: rtl/prbs9_tx_gen.sv
// PRBS9 transmit source: one bit every OS clocks with a valid strobe and +/-1 symbol.
// Optional periodic bit-error injection is compiled in with `define ERR_INJECT_EN.
module prbs9_tx_gen
  import prbs_pkg::*;
#(
  parameter int                  OS   = 4,
  parameter logic [PRBS_LEN-1:0] SEED = SEED_I
`ifdef ERR_INJECT_EN
  ,
  parameter int                  ERR_PERIOD = 1024
`endif
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_load_seed,
  input  logic [PRBS_LEN-1:0] i_seed,
  output logic                o_bit,
  output logic                o_valid,
  output logic [1:0]          o_symbol,
  output logic                o_period_end,
  output logic [63:0]         o_bit_count
`ifdef ERR_INJECT_EN
  ,
  input  logic                i_inj_enable,
  output logic [31:0]         o_inj_count
`endif
);

  localparam int RATE_W = $clog2(OS);

  txState_t            state;
  txState_t            nextState;
  logic [RATE_W-1:0]   rateCnt;
  logic [PRBS_LEN-1:0] periodCnt;
  logic                strobe;
  logic                loadLfsr;
  logic                lfsrOut;
  logic                emitBit;

  prbs9_lfsr #(
    .SEED (SEED)
  ) uLfsr (
    .clock   (clock),
    .i_reset (i_reset),
    .load    (loadLfsr),
    .advance (strobe),
    .seedIn  (i_seed),
    .outBit  (lfsrOut)
  );

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // A seed load in IDLE takes priority over starting; dropping enable in RUN pauses at once
  always_comb begin
    nextState = state;
    strobe    = 1'b0;
    loadLfsr  = 1'b0;
    case (state)
      IDLE: begin
        if (i_load_seed) begin
          nextState = LOAD;
        end else if (i_enable) begin
          nextState = RUN;
        end
      end
      LOAD: begin
        loadLfsr  = 1'b1;
        nextState = i_enable ? RUN : IDLE;
      end
      RUN: begin
        if (!i_enable) begin
          nextState = IDLE;
        end else begin
          strobe = (rateCnt == RATE_W'(OS - 1));
        end
      end
      default: nextState = IDLE;
    endcase
  end

`ifdef ERR_INJECT_EN
  localparam int ERR_W = $clog2(ERR_PERIOD);

  logic [ERR_W-1:0] errCnt;
  logic             injectNow;

  assign injectNow = i_inj_enable && (errCnt == ERR_W'(ERR_PERIOD - 1));
  assign emitBit   = lfsrOut ^ injectNow;

  // errCnt tracks emitted bits regardless of i_inj_enable so the error spacing stays fixed
  always_ff @(posedge clock) begin
    if (i_reset) begin
      errCnt      <= '0;
      o_inj_count <= '0;
    end else if (strobe) begin
      errCnt <= (errCnt == ERR_W'(ERR_PERIOD - 1)) ? '0 : errCnt + 1'b1;
      if (injectNow && o_inj_count != '1) begin
        o_inj_count <= o_inj_count + 1'b1;
      end
    end
  end
`else
  assign emitBit = lfsrOut;
`endif

  // Rate counter restarts on every entry to RUN so a pause never skips or repeats a bit
  always_ff @(posedge clock) begin
    if (i_reset) begin
      rateCnt      <= '0;
      periodCnt    <= '0;
      o_bit        <= 1'b0;
      o_valid      <= 1'b0;
      o_symbol     <= SYM_P1;
      o_period_end <= 1'b0;
      o_bit_count  <= '0;
    end else begin
      o_valid      <= strobe;
      o_period_end <= strobe && (periodCnt == PRBS_LEN'(PRBS_PERIOD - 1));
      if (state != RUN || !i_enable || strobe) begin
        rateCnt <= '0;
      end else begin
        rateCnt <= rateCnt + 1'b1;
      end
      if (loadLfsr) begin
        periodCnt <= '0;
      end else if (strobe) begin
        periodCnt <= (periodCnt == PRBS_LEN'(PRBS_PERIOD - 1)) ? '0 : periodCnt + 1'b1;
      end
      if (strobe) begin
        o_bit       <= emitBit;
        o_symbol    <= symbolOf(emitBit);
        o_bit_count <= o_bit_count + 64'd1;
      end
    end
  end

endmodule
